// File: rtl/lc3_controller_pkg.sv
// Shared types and encodings for the LC3 control FSM: states, opcodes,
// memory-access codes and the opcode classifier that picks the execute successor.
package lc3_pkg;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MIND, S_MRD, S_MWR, S_WB, S_UPDPC
  } state_e;

  typedef enum logic [2:0] {
    OC_ALU, OC_LOAD, OC_IND, OC_STORE, OC_CTRL, OC_NOP
  } op_class_e;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] MEM_RD   = 2'd0;
  localparam logic [1:0] MEM_IND  = 2'd1;
  localparam logic [1:0] MEM_WR   = 2'd2;
  localparam logic [1:0] MEM_IDLE = 2'd3;

  function automatic op_class_e op_class(input logic [3:0] op);
    case (op)
      OP_ADD, OP_AND, OP_NOT, OP_LEA: return OC_ALU;
      OP_LD, OP_LDR:                  return OC_LOAD;
      OP_LDI, OP_STI:                 return OC_IND;
      OP_ST, OP_STR:                  return OC_STORE;
      OP_BR, OP_JMP:                  return OC_CTRL;
      default:                        return OC_NOP;
    endcase
  endfunction

  function automatic logic [1:0] mem_code(input state_e s);
    case (s)
      S_MIND:  return MEM_IND;
      S_MRD:   return MEM_RD;
      S_MWR:   return MEM_WR;
      default: return MEM_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/lc3_controller_if.sv
// Handshake and control bundle between the LC3 controller (master) and the
// datapath/memory stages (slave).
interface lc3_controller_if;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] IR;
  logic [2:0]  psr;
  logic        enable_fetch;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        enable_updatePC;
  logic        br_taken;
  logic [1:0]  mem_state;
  logic        mem_err;

  modport master (
    input  complete_instr, complete_data, IR, psr,
    output enable_fetch, enable_decode, enable_execute, enable_writeback,
           enable_updatePC, br_taken, mem_state, mem_err
  );

  modport slave (
    output complete_instr, complete_data, IR, psr,
    input  enable_fetch, enable_decode, enable_execute, enable_writeback,
           enable_updatePC, br_taken, mem_state, mem_err
  );
endinterface

// File: rtl/lc3_controller.sv
// Multi-cycle LC3 control FSM; every output is a register loaded from the
// next-state decode so it lines up with the state it belongs to.
module lc3_controller
  import lc3_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  lc3_controller_if.master bus
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q;
  logic [2:0]    nzp_q;
  logic          err_d;
  logic          mem_wait;
  logic          en_fetch_q, en_decode_q, en_exec_q, en_wb_q, en_upd_q;
  logic          br_taken_q, mem_err_q;
  logic [1:0]    mem_state_q;
  logic          unused_ir;

  assign unused_ir = ^bus.IR[8:0];
  assign mem_wait  = (state_q == S_MIND) || (state_q == S_MRD) || (state_q == S_MWR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = mem_err_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (bus.complete_instr) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op_class(op_q))
          OC_ALU:   state_d = S_WB;
          OC_LOAD:  state_d = S_MRD;
          OC_IND:   state_d = S_MIND;
          OC_STORE: state_d = S_MWR;
          default:  state_d = S_UPDPC;
        endcase
      end
      S_MIND:   if (bus.complete_data) state_d = (op_q == OP_LDI) ? S_MRD : S_MWR;
      S_MRD:    if (bus.complete_data) state_d = S_WB;
      S_MWR:    if (bus.complete_data) state_d = S_UPDPC;
      S_WB:     state_d = S_UPDPC;
      S_UPDPC:  state_d = S_FETCH;
      default:  state_d = S_RST;
    endcase
    // A handshake on the final allowed cycle wins over the timeout.
    if (mem_wait && !bus.complete_data) begin
      if (cnt_q == CNT_LAST) begin
        state_d = S_UPDPC;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RST;
      cnt_q       <= '0;
      op_q        <= '0;
      nzp_q       <= '0;
      en_fetch_q  <= 1'b0;
      en_decode_q <= 1'b0;
      en_exec_q   <= 1'b0;
      en_wb_q     <= 1'b0;
      en_upd_q    <= 1'b0;
      br_taken_q  <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_state_q <= MEM_IDLE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_err_q   <= err_d;
      en_fetch_q  <= (state_d == S_FETCH);
      en_decode_q <= (state_d == S_DECODE);
      en_exec_q   <= (state_d == S_EXEC);
      en_wb_q     <= (state_d == S_WB);
      en_upd_q    <= (state_d == S_UPDPC);
      mem_state_q <= mem_code(state_d);
      if (state_q == S_DECODE) begin
        op_q  <= bus.IR[15:12];
        nzp_q <= bus.IR[11:9];
      end
      if (state_q == S_EXEC) begin
        br_taken_q <= (op_q == OP_BR) ? |(nzp_q & bus.psr) : (op_q == OP_JMP);
      end
    end
  end

  assign bus.enable_fetch     = en_fetch_q;
  assign bus.enable_decode    = en_decode_q;
  assign bus.enable_execute   = en_exec_q;
  assign bus.enable_writeback = en_wb_q;
  assign bus.enable_updatePC  = en_upd_q;
  assign bus.br_taken         = br_taken_q;
  assign bus.mem_state        = mem_state_q;
  assign bus.mem_err          = mem_err_q;

endmodule

// File: tb/tb_lc3_controller.sv
// Directed, table-driven bench for lc3_controller: one instruction per table row,
// plus hand-written reset sequences.
module tb_lc3_controller;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  lc3_controller_if bus();

  lc3_controller #(.MEM_TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  psr;
    int          delay;   // wait cycles before complete_data in each memory state
    int          cycles;  // fetch cycle through updatePC cycle, inclusive
    bit          wb;
    bit          br;
    int          m1;
    int          m0;
    int          m2;
    bit          err;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fetch"},  int'(bus.enable_fetch), 0);
    chk({tag, "_decode"}, int'(bus.enable_decode), 0);
    chk({tag, "_exec"},   int'(bus.enable_execute), 0);
    chk({tag, "_wb"},     int'(bus.enable_writeback), 0);
    chk({tag, "_upd"},    int'(bus.enable_updatePC), 0);
    chk({tag, "_br"},     int'(bus.br_taken), 0);
    chk({tag, "_mem"},    int'(bus.mem_state), 3);
    chk({tag, "_err"},    int'(bus.mem_err), 0);
  endtask

  // Entered at a negedge with the FSM in S_FETCH; leaves at the negedge after updatePC.
  task automatic run_vec(input int idx);
    vec_t v;
    int cyc, m1, m0, m2, wait_cnt, pos_dec, pos_exec, pos_wb, onehot_bad, act;
    bit wb_seen, done, br_at_upd, err_at_upd;
    logic [1:0] prev_mem;
    v = vecs[idx];
    cyc = 0; m1 = 0; m0 = 0; m2 = 0; wait_cnt = 0; pos_dec = 0; pos_exec = 0;
    pos_wb = 0; onehot_bad = 0; wb_seen = 0; done = 0; br_at_upd = 0; err_at_upd = 0;
    prev_mem = 2'd3;
    bus.IR = v.ir;
    bus.psr = v.psr;
    bus.complete_instr = 1'b1;
    while (!done && cyc < 60) begin
      cyc++;
      act = int'(bus.enable_fetch) + int'(bus.enable_decode) + int'(bus.enable_execute)
          + int'(bus.enable_writeback) + int'(bus.enable_updatePC) + int'(bus.mem_state != 2'd3);
      if (act != 1) onehot_bad++;
      if (bus.enable_decode) pos_dec = cyc;
      if (bus.enable_execute) pos_exec = cyc;
      if (bus.enable_writeback) begin wb_seen = 1; pos_wb = cyc; end
      case (bus.mem_state)
        2'd1: m1++;
        2'd0: m0++;
        2'd2: m2++;
        default: ;
      endcase
      if (bus.mem_state != 2'd3) wait_cnt = (bus.mem_state == prev_mem) ? wait_cnt + 1 : 0;
      prev_mem = bus.mem_state;
      bus.complete_data = (bus.mem_state != 2'd3) && (wait_cnt == v.delay);
      if (bus.enable_updatePC) begin
        done = 1;
        br_at_upd = bus.br_taken;
        err_at_upd = bus.mem_err;
      end
      @(posedge clock);
      @(negedge clock);
    end
    bus.complete_data = 1'b0;
    chk($sformatf("v%0d_done", idx), int'(done), 1);
    chk($sformatf("v%0d_cycles", idx), cyc, v.cycles);
    chk($sformatf("v%0d_wb", idx), int'(wb_seen), int'(v.wb));
    if (v.wb) chk($sformatf("v%0d_wb_pos", idx), pos_wb, v.cycles - 1);
    chk($sformatf("v%0d_dec_pos", idx), pos_dec, 2);
    chk($sformatf("v%0d_exec_pos", idx), pos_exec, 3);
    chk($sformatf("v%0d_br", idx), int'(br_at_upd), int'(v.br));
    chk($sformatf("v%0d_err", idx), int'(err_at_upd), int'(v.err));
    chk($sformatf("v%0d_m1", idx), m1, v.m1);
    chk($sformatf("v%0d_m0", idx), m0, v.m0);
    chk($sformatf("v%0d_m2", idx), m2, v.m2);
    chk($sformatf("v%0d_onehot", idx), onehot_bad, 0);
    chk($sformatf("v%0d_next_fetch", idx), int'(bus.enable_fetch), 1);
    $display("vec %0d ir=%h psr=%b delay=%0d cycles=%0d wb=%0d br=%0d mem(1/0/2)=%0d/%0d/%0d err=%0d",
             idx, v.ir, v.psr, v.delay, cyc, wb_seen, br_at_upd, m1, m0, m2, err_at_upd);
  endtask

  initial begin
    //           ir        psr     dly cyc wb br m1 m0 m2 err
    vecs[0]  = '{16'h1021, 3'b000, 0,  5,  1, 0, 0, 0, 0, 0};  // ADD
    vecs[1]  = '{16'h5000, 3'b000, 0,  5,  1, 0, 0, 0, 0, 0};  // AND
    vecs[2]  = '{16'h903F, 3'b000, 0,  5,  1, 0, 0, 0, 0, 0};  // NOT
    vecs[3]  = '{16'hE000, 3'b000, 0,  5,  1, 0, 0, 0, 0, 0};  // LEA
    vecs[4]  = '{16'h2000, 3'b000, 0,  6,  1, 0, 0, 1, 0, 0};  // LD
    vecs[5]  = '{16'h6000, 3'b000, 1,  7,  1, 0, 0, 2, 0, 0};  // LDR, 1 wait
    vecs[6]  = '{16'h3005, 3'b000, 0,  5,  0, 0, 0, 0, 1, 0};  // ST
    vecs[7]  = '{16'h7000, 3'b000, 3,  8,  0, 0, 0, 0, 4, 0};  // STR, 3 waits
    vecs[8]  = '{16'hA402, 3'b000, 2,  11, 1, 0, 3, 3, 0, 0};  // LDI, 2 waits each
    vecs[9]  = '{16'hB000, 3'b000, 0,  6,  0, 0, 1, 0, 1, 0};  // STI
    vecs[10] = '{16'h0402, 3'b010, 0,  4,  0, 1, 0, 0, 0, 0};  // BRz taken
    vecs[11] = '{16'h0402, 3'b001, 0,  4,  0, 0, 0, 0, 0, 0};  // BRz not taken
    vecs[12] = '{16'h0000, 3'b111, 0,  4,  0, 0, 0, 0, 0, 0};  // BR nzp=000
    vecs[13] = '{16'hC1C0, 3'b000, 0,  4,  0, 1, 0, 0, 0, 0};  // JMP
    vecs[14] = '{16'hF025, 3'b000, 0,  4,  0, 0, 0, 0, 0, 0};  // TRAP
    vecs[15] = '{16'h8000, 3'b000, 0,  4,  0, 0, 0, 0, 0, 0};  // RTI
    vecs[16] = '{16'h2000, 3'b000, 14, 20, 1, 0, 0, 15, 0, 0}; // LD, handshake on last cycle
    vecs[17] = '{16'h3005, 3'b000, 14, 19, 0, 0, 0, 0, 15, 0}; // ST, handshake on last cycle
    vecs[18] = '{16'h3005, 3'b000, 99, 19, 0, 0, 0, 0, 15, 1}; // ST timeout
    vecs[19] = '{16'h1021, 3'b000, 0,  5,  1, 0, 0, 0, 0, 1};  // ADD, err sticky
    vecs[20] = '{16'hB000, 3'b000, 99, 19, 0, 0, 15, 0, 0, 1}; // STI timeout in indirect read

    bus.complete_instr = 1'b0;
    bus.complete_data  = 1'b0;
    bus.IR  = 16'h0000;
    bus.psr = 3'b000;

    // Reset held across edges, then released; FSM must pass S_RST then wait in S_FETCH.
    repeat (3) @(negedge clock);
    chk_reset_outputs("rst_hold");
    reset = 1'b1;
    #1 chk("rst_release_fetch", int'(bus.enable_fetch), 0);
    @(negedge clock);
    chk("rst_first_fetch", int'(bus.enable_fetch), 1);
    chk("rst_first_mem", int'(bus.mem_state), 3);
    @(negedge clock);
    chk("fetch_wait_fetch", int'(bus.enable_fetch), 1);
    chk("fetch_wait_decode", int'(bus.enable_decode), 0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Asynchronous reset while waiting on a store write.
    begin
      int guard;
      guard = 0;
      bus.IR = 16'h3005;
      bus.complete_instr = 1'b1;
      bus.complete_data = 1'b0;
      while (bus.mem_state != 2'd2 && guard < 20) begin
        @(posedge clock);
        @(negedge clock);
        guard++;
      end
      chk("async_reached_mwr", int'(bus.mem_state), 2);
      #2 reset = 1'b0;
      #1 chk_reset_outputs("async");
      $display("async reset during store wait: mem_state=%0d fetch=%0d err=%0d",
               bus.mem_state, bus.enable_fetch, bus.mem_err);
      @(negedge clock);
      reset = 1'b1;
      #1 chk("async_release_rst", int'(bus.enable_fetch), 0);
      @(negedge clock);
      chk("async_then_fetch", int'(bus.enable_fetch), 1);
      chk("async_then_mem", int'(bus.mem_state), 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_controller.md
# lc3_controller

Multi-cycle control FSM for the LC3 datapath; sequences fetch, decode, execute, memory access, writeback and PC update. Drives the 2-bit `mem_state` code consumed directly by the memory-access stage:

- 0 = load read
- 1 = indirect-address read
- 2 = store write
- 3 = idle, memory bus floated

It waits on memory completion handshakes, resolves branch decisions, and bounds every memory wait with a timeout.

## Interface
Parameters:
- `MEM_TIMEOUT`, 15 — max cycles in any memory-wait state before abort.

Ports:
- `clock` in 1 — single clock; all state updates on rising edge.
- `reset` in 1 — asynchronous, active-low; asserting it forces the reset state immediately.
- `complete_instr` in 1 — instruction memory has returned the fetched word.
- `complete_data` in 1 — data memory access finished.
- `IR` in 16 — current instruction word from fetch.
- `psr` in 3 — N,Z,P condition flags from writeback.
- `enable_fetch` out 1 — fetch stage enable.
- `enable_decode` out 1 — decode stage enable.
- `enable_execute` out 1 — execute stage enable.
- `enable_writeback` out 1 — register-file write enable.
- `enable_updatePC` out 1 — PC register load enable.
- `br_taken` out 1 — PC mux selects branch/jump target.
- `mem_state` out 2 — memory-access code, as defined above.
- `mem_err` out 1 — sticky; set on memory timeout.

## Operation
- Moore FSM. All outputs are registered and decoded from the state register.
- States: `S_RST`, `S_FETCH`, `S_DECODE`, `S_EXEC`, `S_MIND`, `S_MRD`, `S_MWR`, `S_WB`, `S_UPDPC`.
- `S_RST`: all enables 0, `mem_state`=3. Unconditionally goes to `S_FETCH` on the next cycle.
- `S_FETCH`: `enable_fetch`=1. Stays until `complete_instr`=1, then goes to `S_DECODE`.
- `S_DECODE`: `enable_decode`=1. Latches `IR[15:12]` and `IR[11:9]` into internal `op_q`/`nzp_q`. Goes to `S_EXEC`.
- `S_EXEC`: `enable_execute`=1. Next state is chosen by `op_q`:
  - ADD 0001, AND 0101, NOT 1001, LEA 1110 → `S_WB`
  - LD 0010, LDR 0110 → `S_MRD`
  - LDI 1010, STI 1011 → `S_MIND`
  - ST 0011, STR 0111 → `S_MWR`
  - BR 0000, JMP 1100 → `S_UPDPC`
  - anything else (RTI 1000, reserved 1101, TRAP 1111) → `S_UPDPC`, no writeback.
- `br_taken` is registered on exit from `S_EXEC`:
  - BR: `|(nzp_q & psr)`
  - JMP: 1
  - everything else: 0
  - Held until the next exit from `S_EXEC`.
- `S_MIND`: `mem_state`=1. On `complete_data`, goes to `S_MRD` for LDI or `S_MWR` for STI.
- `S_MRD`: `mem_state`=0. On `complete_data`, goes to `S_WB`.
- `S_MWR`: `mem_state`=2. On `complete_data`, goes to `S_UPDPC`.
- `S_WB`: `enable_writeback`=1. Goes to `S_UPDPC`.
- `S_UPDPC`: `enable_updatePC`=1. Goes to `S_FETCH`.
- `mem_state`=3 in every state other than `S_MIND`, `S_MRD` and `S_MWR`.
- Timeout counter (width `$clog2(MEM_TIMEOUT+1)`):
  - Cleared on entry to each memory-wait state; increments each cycle the FSM waits there.
  - When it reaches `MEM_TIMEOUT` without `complete_data`: set `mem_err`, go to `S_UPDPC`, skip any writeback.
  - `complete_data` on the same cycle the count hits the limit counts as success; `mem_err` stays unchanged.
- `mem_err` is cleared only by reset.

## Timing
- Reset values: all enables 0, `br_taken`=0, `mem_state`=2'b11, `mem_err`=0, state=`S_RST`.
- Reset asserted mid-instruction: outputs go to reset values asynchronously. Any pending memory access is dropped (`mem_state` goes to 3).
- `complete_*` is sampled on the clock edge. The state changes on that edge, so outputs for the next state appear 1 cycle after the handshake.
- A `complete_*` asserted in a state that is not waiting for it is ignored.
- Minimum cycles per instruction (zero-wait memory, handshake asserted on the first cycle of each wait state):
  - ALU/LEA: 5
  - BR/JMP: 4
  - LD: 6
  - ST: 5
  - LDI: 7
  - STI: 6

## Structure
- `lc3_pkg` holds:
  - the state enum
  - opcode localparams
  - `mem_state` encodings `MEM_RD=0`, `MEM_IND=1`, `MEM_WR=2`, `MEM_IDLE=3`
  - a function `op_class(op) → {ALU, LOAD, IND, STORE, CTRL, NOP}`
- No sub-module; a single FSM plus one counter.

## Test plan
- Reset released, `complete_instr` held 1, IR=0x1021 (ADD) → enables pulse in the order fetch, decode, exec, wb, updPC; `mem_state`=3 throughout.
- IR=0xA402 (LDI), `complete_data` asserted 2 cycles after each wait-state entry → `mem_state` sequence 1,1,1 then 0,0,0, then `enable_writeback`=1.
- IR=0x0402 (BRz): with psr=3'b010 → `br_taken`=1 during `S_UPDPC`; with psr=3'b001 → `br_taken`=0.
- IR=0x3005 (ST), `complete_data` never asserted → `mem_state`=2 for exactly 15 cycles, then `mem_err`=1, then `enable_updatePC`, then the next fetch.
- `reset` asserted low during `S_MWR` → `mem_state`=3 and all enables 0 immediately (asynchronously); after release, the sequence is `S_RST` then `S_FETCH`.
- IR=0xF025 (TRAP) → no writeback, no memory access; `enable_updatePC` in the 4th cycle after fetch completes.
